// File: rtl/tape_recorder_if.sv
// Tape cache write port: the recorder drives a one-cycle strobe with address and data.
interface tape_recorder_if #(
  parameter int ADDR_W = 16
);
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr, wr_addr, wr_data);
  modport slave  (input  wr, wr_addr, wr_data);
endinterface

// File: rtl/tape_recorder.sv
// Cassette record path: measures K7_TAPEOUT rising-edge periods, decodes Oric
// bit/byte framing and appends the decoded bytes to the tape cache.
module tape_recorder #(
  parameter int ADDR_W     = 16,
  parameter int MIN_PERIOD = 2400,
  parameter int BIT_THRESH = 7500,
  parameter int MAX_PERIOD = 24000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            en,
  input  logic            clear,
  input  logic            tape_out,
  tape_recorder_if.master cache,
  output logic [ADDR_W:0] length,
  output logic            active,
  output logic            parity_err,
  output logic            frame_err,
  output logic            full
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] MIN_P    = 16'(MIN_PERIOD);
  localparam logic [15:0] THRESH_P = 16'(BIT_THRESH);
  localparam logic [15:0] MAX_P    = 16'(MAX_PERIOD);

  state_t            state;
  logic [2:0]        tape_sync;
  logic [15:0]       cnt;
  logic              have_ref;
  logic [2:0]        bitcnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [ADDR_W-1:0] ptr;

  logic rise;
  logic bit_val;
  logic period_ok;
  logic timeout;

  // Two flops resynchronize the line; the third only serves edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tape_sync <= '0;
    end else begin
      tape_sync <= {tape_sync[1:0], tape_out};
    end
  end

  assign rise      = tape_sync[1] & ~tape_sync[2];
  assign bit_val   = (cnt < THRESH_P);
  assign period_ok = (cnt >= MIN_P);
  assign timeout   = have_ref && (cnt >= MAX_P);
  assign active    = (state != IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      have_ref      <= 1'b0;
      bitcnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      ptr           <= '0;
      length        <= '0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      full          <= 1'b0;
      cache.wr      <= 1'b0;
      cache.wr_addr <= '0;
      cache.wr_data <= '0;
    end else if (clear) begin
      state         <= IDLE;
      cnt           <= '0;
      have_ref      <= 1'b0;
      bitcnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      ptr           <= '0;
      length        <= '0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      full          <= 1'b0;
      cache.wr      <= 1'b0;
      cache.wr_addr <= '0;
      cache.wr_data <= '0;
    end else begin
      cache.wr <= 1'b0;
      if (!en) begin
        // Disarming abandons the byte in flight but keeps ptr/length so re-arming appends.
        state    <= IDLE;
        have_ref <= 1'b0;
        cnt      <= '0;
      end else begin
        if (cnt != 16'hFFFF) begin
          cnt <= cnt + 16'd1;
        end
        if (rise) begin
          if (!have_ref) begin
            cnt      <= '0;
            have_ref <= 1'b1;
          end else if (period_ok) begin
            cnt <= '0;
            case (state)
              IDLE: begin
                if (!bit_val) begin
                  state  <= DATA;
                  bitcnt <= '0;
                end
              end
              DATA: begin
                shreg  <= {bit_val, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                  state <= PARITY;
                end
              end
              PARITY: begin
                par_bit <= bit_val;
                state   <= STOP;
              end
              STOP: begin
                state <= IDLE;
                if (bit_val) begin
                  // Odd parity over data plus parity bit; a bad byte is still stored.
                  if (!(^shreg ^ par_bit)) begin
                    parity_err <= 1'b1;
                  end
                  if (!full) begin
                    cache.wr      <= 1'b1;
                    cache.wr_addr <= ptr;
                    cache.wr_data <= shreg;
                    ptr           <= ptr + ADDR_W'(1);
                    length        <= length + (ADDR_W+1)'(1);
                    if (ptr == '1) begin
                      full <= 1'b1;
                    end
                  end
                end else begin
                  frame_err <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end else if (timeout) begin
          have_ref <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder with time constants scaled down 100x so
// whole bytes fit in a short run; bit 1 = 50-cycle period, bit 0 = 100-cycle.
module tb_tape_recorder;

  localparam int ADDR_W = 4;
  localparam int P1     = 50;
  localparam int P0     = 100;

  logic            clk_sys;
  logic            reset;
  logic            en;
  logic            clear;
  logic            tape_out;
  logic [ADDR_W:0] length;
  logic            active;
  logic            parity_err;
  logic            frame_err;
  logic            full;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [7:0]        cap_data[$];

  tape_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  tape_recorder #(
    .ADDR_W(ADDR_W),
    .MIN_PERIOD(24),
    .BIT_THRESH(75),
    .MAX_PERIOD(240)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .en(en),
    .clear(clear),
    .tape_out(tape_out),
    .cache(bus.master),
    .length(length),
    .active(active),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .full(full)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (bus.wr === 1'b1) begin
      cap_addr.push_back(bus.wr_addr);
      cap_data.push_back(bus.wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // A 0 bit may carry a short low dip right after its rising edge; the extra edge lands below MIN_PERIOD.
  task automatic sendBit(input logic b, input logic glitch);
    if (!b && glitch) begin
      tape_out = 1'b1; waitCycles(5);
      tape_out = 1'b0; waitCycles(5);
      tape_out = 1'b1; waitCycles(P0/2 - 10);
      tape_out = 1'b0; waitCycles(P0/2);
    end else begin
      tape_out = 1'b1; waitCycles((b ? P1 : P0) / 2);
      tape_out = 1'b0; waitCycles((b ? P1 : P0) / 2);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input int leader, input logic glitch);
    for (int i = 0; i < leader; i++) sendBit(1'b1, 1'b0);
    sendBit(1'b0, glitch);
    for (int i = 0; i < 8; i++) sendBit(data[i], glitch);
    sendBit(par, glitch);
    sendBit(stop, glitch);
    tape_out = 1'b1; waitCycles(25);
    tape_out = 1'b0; waitCycles(300);
  endtask

  task automatic doClear();
    clear = 1'b1;
    waitCycles(1);
    clear = 1'b0;
    waitCycles(2);
    cap_addr.delete();
    cap_data.delete();
  endtask

  initial begin
    logic [7:0] b;
    reset    = 1'b1;
    en       = 1'b0;
    clear    = 1'b0;
    tape_out = 1'b0;
    waitCycles(4);
    reset = 1'b0;
    waitCycles(2);

    checkOutput("rst_wr", 32'(bus.wr), 0);
    checkOutput("rst_length", 32'(length), 0);
    checkOutput("rst_active", 32'(active), 0);
    checkOutput("rst_flags", 32'({parity_err, frame_err, full}), 0);
    checkOutput("rst_addr_data", 32'({bus.wr_addr, bus.wr_data}), 0);

    en = 1'b1;
    waitCycles(2);

    // Clean byte with a long leader.
    applyStimulus(8'h16, 1'b0, 1'b1, 20, 1'b0);
    checkOutput("clean_count", 32'(cap_addr.size()), 1);
    checkOutput("clean_addr", 32'(cap_addr[0]), 0);
    checkOutput("clean_data", 32'(cap_data[0]), 32'h16);
    checkOutput("clean_length", 32'(length), 1);
    checkOutput("clean_perr", 32'(parity_err), 0);
    checkOutput("clean_ferr", 32'(frame_err), 0);
    checkOutput("clean_active", 32'(active), 0);

    // Parity error: byte stored anyway, flag sticky across a good byte.
    doClear();
    checkOutput("clear_length", 32'(length), 0);
    applyStimulus(8'h16, 1'b1, 1'b1, 3, 1'b0);
    checkOutput("par_count", 32'(cap_addr.size()), 1);
    checkOutput("par_data", 32'(cap_data[0]), 32'h16);
    checkOutput("par_addr", 32'(cap_addr[0]), 0);
    checkOutput("par_flag", 32'(parity_err), 1);
    applyStimulus(8'h24, 1'b1, 1'b1, 3, 1'b0);
    checkOutput("par2_count", 32'(cap_addr.size()), 2);
    checkOutput("par2_addr", 32'(cap_addr[1]), 1);
    checkOutput("par2_data", 32'(cap_data[1]), 32'h24);
    checkOutput("par2_flag", 32'(parity_err), 1);
    checkOutput("par2_length", 32'(length), 2);

    // Timeout: start + 4 data bits, then the line stays high past MAX_PERIOD.
    doClear();
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    b = 8'h24;
    for (int i = 0; i < 4; i++) sendBit(b[i], 1'b0);
    tape_out = 1'b1; waitCycles(360);
    checkOutput("tmo_active", 32'(active), 0);
    checkOutput("tmo_count", 32'(cap_addr.size()), 0);
    checkOutput("tmo_flags", 32'({parity_err, frame_err}), 0);
    tape_out = 1'b0; waitCycles(50);
    applyStimulus(8'h24, 1'b1, 1'b1, 3, 1'b0);
    checkOutput("tmo2_count", 32'(cap_addr.size()), 1);
    checkOutput("tmo2_addr", 32'(cap_addr[0]), 0);
    checkOutput("tmo2_data", 32'(cap_data[0]), 32'h24);
    checkOutput("tmo2_length", 32'(length), 1);

    // Glitch edges inside every 0-bit period.
    doClear();
    applyStimulus(8'hA5, 1'b1, 1'b1, 3, 1'b1);
    checkOutput("glitch_count", 32'(cap_addr.size()), 1);
    checkOutput("glitch_data", 32'(cap_data[0]), 32'hA5);
    checkOutput("glitch_flags", 32'({parity_err, frame_err}), 0);

    // Frame error, then recovery.
    doClear();
    applyStimulus(8'h55, 1'b1, 1'b0, 3, 1'b0);
    checkOutput("frame_count", 32'(cap_addr.size()), 0);
    checkOutput("frame_flag", 32'(frame_err), 1);
    checkOutput("frame_active", 32'(active), 0);
    applyStimulus(8'h16, 1'b0, 1'b1, 3, 1'b0);
    checkOutput("frame2_count", 32'(cap_addr.size()), 1);
    checkOutput("frame2_data", 32'(cap_data[0]), 32'h16);
    checkOutput("frame2_addr", 32'(cap_addr[0]), 0);
    checkOutput("frame2_perr", 32'(parity_err), 0);
    checkOutput("frame2_ferr", 32'(frame_err), 1);

    // Fill the 16-byte cache with 17 bytes.
    doClear();
    for (int i = 0; i <= 16; i++) begin
      b = 8'(i);
      applyStimulus(b, ~^b, 1'b1, 2, 1'b0);
    end
    checkOutput("full_count", 32'(cap_addr.size()), 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("full_addr", (i < cap_addr.size()) ? 32'(cap_addr[i]) : 32'hDEAD, 32'(i));
      checkOutput("full_data", (i < cap_data.size()) ? 32'(cap_data[i]) : 32'hDEAD, 32'(i));
    end
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("full_length", 32'(length), 16);
    checkOutput("full_perr", 32'(parity_err), 0);

    // Reset asynchronously in the middle of a byte.
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    checkOutput("mid_active", 32'(active), 1);
    reset = 1'b1;
    #1;
    checkOutput("arst_wr", 32'(bus.wr), 0);
    checkOutput("arst_addr", 32'(bus.wr_addr), 0);
    checkOutput("arst_data", 32'(bus.wr_data), 0);
    checkOutput("arst_length", 32'(length), 0);
    checkOutput("arst_active", 32'(active), 0);
    checkOutput("arst_flags", 32'({parity_err, frame_err, full}), 0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
